// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen
// Multi-channel quadrature encoder emulator. Each channel turns either a
// relative left/right request or an absolute position target into a stream
// of quadrature steps on {A,B}, paced by a shared step-period divider that
// shortens as a channel keeps stepping in the same direction.
//
// Per-channel stepping, for a teammate binding checkers:
//   - requests are taken from the registered input copies only;
//   - a step fires when the request is active and the (effective) timer is 0;
//     quad, pos and the step strobe all update on that same clock edge;
//   - the timer reloads with period-1, where period = max(clkdiv >> stage, 1);
//   - idle (no request) forces timer, stage and step count to 0;
//   - a mode change behaves as if the timer were 0 and the stage/count were
//     clear, so a pending request in the new mode steps without extra delay.
module quad_encoder_gen #(
   parameter int         CHANNELS    = 2,
   parameter int         DIV_W       = 16,
   parameter int         ACCEL_STEPS = 8,
   parameter int         MAX_SHIFT   = 3,
   parameter logic [7:0] POS_INIT    = 8'h80
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [DIV_W-1:0]      clkdiv,
   input  logic [CHANNELS-1:0]   left,
   input  logic [CHANNELS-1:0]   right,
   input  logic [CHANNELS-1:0]   mode,
   input  logic [8*CHANNELS-1:0] target,
   output logic [2*CHANNELS-1:0] quad,
   output logic [8*CHANNELS-1:0] pos,
   output logic [CHANNELS-1:0]   step
);

   // Stage counts 0..MAX_SHIFT; the step count runs 0..ACCEL_STEPS-1.
   localparam int STG_W = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1);
   localparam int CNT_W = (ACCEL_STEPS < 2) ? 1 : $clog2(ACCEL_STEPS + 1);

   localparam logic [STG_W-1:0] STG_MAX = STG_W'(MAX_SHIFT);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ACCEL_STEPS);

   // Registered copies of the request inputs.
   logic [CHANNELS-1:0]            left_r;
   logic [CHANNELS-1:0]            right_r;
   logic [CHANNELS-1:0]            mode_r;
   logic [CHANNELS-1:0]            mode_q;   // mode_r one cycle later, for change detect
   logic [CHANNELS-1:0][7:0]       target_r;

   // Per-channel stepping state and its next-state values.
   logic [CHANNELS-1:0][DIV_W-1:0] timer_q,    timer_d;
   logic [CHANNELS-1:0][STG_W-1:0] stage_q,    stage_d;
   logic [CHANNELS-1:0][CNT_W-1:0] count_q,    count_d;
   logic [CHANNELS-1:0]            last_dec_q, last_dec_d;
   logic [CHANNELS-1:0][1:0]       quad_q,     quad_d;
   logic [CHANNELS-1:0][7:0]       pos_q,      pos_d;
   logic [CHANNELS-1:0]            step_q,     step_d;

   // Next Gray code on {A,B}: forward 00->01->11->10->00, reverse the opposite.
   function automatic logic [1:0] quad_advance(input logic [1:0] q, input logic dec);
      logic [1:0] r;
      r = q;
      if (!dec) begin
         case (q)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
         endcase
      end else begin
         case (q)
            2'b00:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
         endcase
      end
      return r;
   endfunction

   // Timer reload for a given stage: max(div >> stage, 1) - 1.
   // A divider of 0 (or one shifted down to 0) gives one step per cycle.
   function automatic logic [DIV_W-1:0] reload_value(input logic [DIV_W-1:0] div,
                                                     input logic [STG_W-1:0] stg);
      logic [DIV_W-1:0] shifted;
      shifted = div >> stg;
      if (shifted == '0) begin
         return '0;
      end
      return shifted - DIV_W'(1);
   endfunction

   // Input register stage: every decision below uses only these copies.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         left_r   <= '0;
         right_r  <= '0;
         mode_r   <= '0;
         mode_q   <= '0;
         target_r <= '0;
      end else begin
         left_r   <= left;
         right_r  <= right;
         mode_r   <= mode;
         mode_q   <= mode_r;
         target_r <= target;
      end
   end

   // Per-channel request decode, step decision, acceleration and position update.
   always_comb begin : chan_next
      logic             inc;
      logic             dec;
      logic             active;
      logic             mode_chg;
      logic             reversal;
      logic [DIV_W-1:0] timer_eff;
      logic [STG_W-1:0] stage_eff;
      logic [CNT_W-1:0] count_eff;
      logic [CNT_W-1:0] count_inc;

      timer_d    = timer_q;
      stage_d    = stage_q;
      count_d    = count_q;
      last_dec_d = last_dec_q;
      quad_d     = quad_q;
      pos_d      = pos_q;
      step_d     = '0;

      inc        = 1'b0;
      dec        = 1'b0;
      active     = 1'b0;
      mode_chg   = 1'b0;
      reversal   = 1'b0;
      timer_eff  = '0;
      stage_eff  = '0;
      count_eff  = '0;
      count_inc  = '0;

      for (int n = 0; n < CHANNELS; n++) begin
         // Request direction: absolute mode chases the target and never
         // wraps; relative mode is right XOR left.
         if (mode_r[n]) begin
            inc = (pos_q[n] < target_r[n]);
            dec = (pos_q[n] > target_r[n]);
         end else begin
            inc = right_r[n] & ~left_r[n];
            dec = left_r[n] & ~right_r[n];
         end
         active   = inc | dec;
         mode_chg = mode_r[n] ^ mode_q[n];

         // A mode change or a direction reversal restarts the pacing.
         timer_eff = mode_chg ? '0 : timer_q[n];
         reversal  = active && (dec != last_dec_q[n]);
         stage_eff = (mode_chg || reversal) ? '0 : stage_q[n];
         count_eff = (mode_chg || reversal) ? '0 : count_q[n];
         count_inc = count_eff + CNT_W'(1);

         if (!active) begin
            timer_d[n] = '0;
            stage_d[n] = '0;
            count_d[n] = '0;
         end else if (timer_eff == '0) begin
            step_d[n]     = 1'b1;
            timer_d[n]    = reload_value(clkdiv, stage_eff);
            quad_d[n]     = quad_advance(quad_q[n], dec);
            pos_d[n]      = dec ? (pos_q[n] - 8'd1) : (pos_q[n] + 8'd1);
            last_dec_d[n] = dec;
            // The reload above uses the stage in force before this step;
            // the faster period applies from the next reload on.
            if (count_inc == CNT_LIM) begin
               count_d[n] = '0;
               stage_d[n] = (stage_eff == STG_MAX) ? stage_eff : (stage_eff + STG_W'(1));
            end else begin
               count_d[n] = count_inc;
               stage_d[n] = stage_eff;
            end
         end else begin
            timer_d[n] = timer_eff - DIV_W'(1);
            stage_d[n] = stage_eff;
            count_d[n] = count_eff;
         end
      end
   end

   // Per-channel state register; reset parks every channel at POS_INIT, phase 00.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         timer_q    <= '0;
         stage_q    <= '0;
         count_q    <= '0;
         last_dec_q <= '0;
         quad_q     <= '0;
         pos_q      <= {CHANNELS{POS_INIT}};
         step_q     <= '0;
      end else begin
         timer_q    <= timer_d;
         stage_q    <= stage_d;
         count_q    <= count_d;
         last_dec_q <= last_dec_d;
         quad_q     <= quad_d;
         pos_q      <= pos_d;
         step_q     <= step_d;
      end
   end

   // Packed state maps directly onto the output buses: channel n phase A at
   // quad[2n+1], phase B at quad[2n], position at pos[8n+7:8n].
   assign quad = quad_q;
   assign pos  = pos_q;
   assign step = step_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: a default two-channel instance plus a
// one-channel instance with fast acceleration (ACCEL_STEPS=2, MAX_SHIFT=1).
module tb_quad_encoder_gen;

  logic        clk_sys;
  logic        reset;
  logic [15:0] clkdiv;

  logic [1:0]  left;
  logic [1:0]  right;
  logic [1:0]  mode;
  logic [15:0] target;
  logic [3:0]  quad;
  logic [15:0] pos;
  logic [1:0]  step;

  logic [0:0]  a_left;
  logic [0:0]  a_right;
  logic [0:0]  a_mode;
  logic [7:0]  a_target;
  logic [1:0]  a_quad;
  logic [7:0]  a_pos;
  logic [0:0]  a_step;

  int vec_cnt = 0;
  int err_cnt = 0;

  // {A,B} after n forward / reverse steps from 00, indexed by n mod 4.
  logic [1:0] qf [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] qr [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_gen dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clkdiv  (clkdiv),
    .left    (left),
    .right   (right),
    .mode    (mode),
    .target  (target),
    .quad    (quad),
    .pos     (pos),
    .step    (step)
  );

  quad_encoder_gen #(
    .CHANNELS    (1),
    .DIV_W       (16),
    .ACCEL_STEPS (2),
    .MAX_SHIFT   (1),
    .POS_INIT    (8'h80)
  ) dut_acc (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clkdiv  (clkdiv),
    .left    (a_left),
    .right   (a_right),
    .mode    (a_mode),
    .target  (a_target),
    .quad    (a_quad),
    .pos     (a_pos),
    .step    (a_step)
  );

  // ---------------- clock / reset ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released, so
  // the next rising edge is edge 0 of the following test.
  task automatic apply_reset();
    left     = '0;
    right    = '0;
    mode     = '0;
    target   = '0;
    a_left   = '0;
    a_right  = '0;
    a_mode   = '0;
    a_target = '0;
    reset    = 1'b1;
    #2;
    check("rst_quad",   32'(quad),   32'h0);
    check("rst_pos",    32'(pos),    32'h8080);
    check("rst_step",   32'(step),   32'h0);
    check("rst_a_pos",  32'(a_pos),  32'h80);
    check("rst_a_quad", 32'(a_quad), 32'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    logic       exp_s;
    logic [7:0] e8;
    int         ns;

    reset  = 1'b1;
    clkdiv = '0;

    // Basic pacing: clkdiv=4, ch0 right held 12 cycles -> steps at 1,5,9.
    apply_reset();
    clkdiv = 16'd4;
    right  = 2'b01;
    ns     = 0;
    for (int e = 0; e < 16; e++) begin
      if (e == 12) right = 2'b00;
      tick();
      exp_s = (e == 1 || e == 5 || e == 9);
      if (exp_s) ns++;
      check("t1_step", 32'(step[0]), 32'(exp_s));
      check("t1_pos",  32'(pos[7:0]), 32'(8'h80 + ns));
      check("t1_quad", 32'(quad[1:0]), 32'(qf[ns % 4]));
    end
    check("t1_ch1", 32'({quad[3:2], pos[15:8], step[1]}), 32'({2'b00, 8'h80, 1'b0}));

    // Acceleration: clkdiv=8 -> gaps 8,8,4,4,4; release and re-press -> 8 again.
    apply_reset();
    clkdiv  = 16'd8;
    a_right = 1'b1;
    for (int e = 0; e < 31; e++) begin
      tick();
      exp_s = (e inside {1, 9, 17, 21, 25, 29});
      check("t2_step", 32'(a_step), 32'(exp_s));
    end
    check("t2_pos", 32'(a_pos), 32'h86);
    a_right = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("t2_idle", 32'(a_step), 32'h0);
    end
    a_right = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_s = (k == 1 || k == 9);
      check("t2_repress", 32'(a_step), 32'(exp_s));
    end
    a_right = 1'b0;

    // Relative wrap with clkdiv=0: 129 left steps from 0x80 -> 0xFF, then
    // one right step wraps to 0x00; both held -> idle.
    apply_reset();
    clkdiv = 16'd0;
    left   = 2'b01;
    repeat (129) tick();
    left = 2'b00;
    tick();
    tick();
    check("t3_pos_ff", 32'(pos[7:0]), 32'hFF);
    check("t3_quad",   32'(quad[1:0]), 32'(2'b10));
    right = 2'b01;
    tick();
    right = 2'b00;
    tick();
    check("t3_wrap_step", 32'(step[0]), 32'h1);
    check("t3_wrap_pos",  32'(pos[7:0]), 32'h00);
    check("t3_wrap_quad", 32'(quad[1:0]), 32'(2'b00));
    tick();
    check("t3_one_step", 32'(step[0]), 32'h0);
    left  = 2'b01;
    right = 2'b01;
    for (int e = 0; e < 20; e++) begin
      tick();
      check("t3_both_step", 32'(step[0]), 32'h0);
    end
    check("t3_both_quad", 32'(quad[1:0]), 32'(2'b00));
    check("t3_both_pos",  32'(pos[7:0]), 32'h00);
    left  = 2'b00;
    right = 2'b00;

    // Absolute mode: ch0 target 0x83 then back to 0x80; ch1 target == pos stays idle.
    apply_reset();
    clkdiv = 16'd1;
    mode   = 2'b11;
    target = {8'h80, 8'h83};
    for (int e = 0; e < 6; e++) begin
      tick();
      exp_s = (e >= 1 && e <= 3);
      ns    = (e > 3) ? 3 : e;
      check("t4_up_step", 32'(step), 32'({1'b0, exp_s}));
      check("t4_up_pos",  32'(pos[7:0]), 32'(8'h80 + ns));
    end
    check("t4_up_quad", 32'(quad[1:0]), 32'(2'b10));
    target[7:0] = 8'h80;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_s = (k >= 1 && k <= 3);
      ns    = (k > 3) ? 3 : k;
      check("t4_dn_step", 32'(step), 32'({1'b0, exp_s}));
      check("t4_dn_pos",  32'(pos[7:0]), 32'(8'h83 - ns));
    end
    check("t4_dn_quad", 32'(quad), 32'h0);
    check("t4_ch1_pos", 32'(pos[15:8]), 32'h80);
    mode = 2'b00;

    // Independent channels: ch0 right, ch1 left, clkdiv=2 -> coincident steps.
    apply_reset();
    clkdiv = 16'd2;
    right  = 2'b01;
    left   = 2'b10;
    for (int e = 0; e < 8; e++) begin
      tick();
      ns = (e + 1) / 2;
      e8 = 8'h80 - 8'(ns);
      check("t5_step",  32'(step), (e % 2 == 1) ? 32'h3 : 32'h0);
      check("t5_quad0", 32'(quad[1:0]), 32'(qf[ns % 4]));
      check("t5_quad1", 32'(quad[3:2]), 32'(qr[ns % 4]));
      check("t5_pos0",  32'(pos[7:0]), 32'(8'h80 + ns));
      check("t5_pos1",  32'(pos[15:8]), 32'(e8));
    end
    right = 2'b00;
    left  = 2'b00;

    // Mid-sequence reset takes effect at once; first step after release at edge 1.
    apply_reset();
    clkdiv = 16'd1;
    right  = 2'b01;
    tick();
    tick();
    tick();
    check("t6_pre_pos",  32'(pos[7:0]), 32'h82);
    check("t6_pre_step", 32'(step[0]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_quad", 32'(quad), 32'h0);
    check("t6_async_pos",  32'(pos), 32'h8080);
    check("t6_async_step", 32'(step), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_e0_step", 32'(step[0]), 32'h0);
    check("t6_e0_pos",  32'(pos[7:0]), 32'h80);
    tick();
    check("t6_e1_step", 32'(step[0]), 32'h1);
    check("t6_e1_pos",  32'(pos[7:0]), 32'h81);
    check("t6_e1_quad", 32'(quad[1:0]), 32'(2'b01));
    right = 2'b00;

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
